alu: RTL
========

// Module: alu
// PURPOSE
//  8-bit 6502 arithmetic/logic unit, the stage directly downstream of proc's ALU operand registers.
//  Accepts operation, operands, carry-in and decimal-mode bit on a one-cycle request strobe.
//  Returns a registered result and a status-flag byte laid out bit-for-bit like P.
//  proc consumes alu_Y/alu_flags when alu_valid is high.
// PARAMETERS
//  BCD_ENABLE  1  1 = NMOS decimal ADD/SUB; 0 = alu_BCD ignored, all arithmetic is binary
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  resetn     in   1  asynchronous, active-low reset
//  alu_req    in   1  one-cycle strobe: operands valid, start operation
//  alu_ctrl   in   3  operation select (encodings in params.vh)
//  alu_AI     in   8  operand A
//  alu_BI     in   8  operand B; ignored by shifts
//  alu_carry  in   1  carry-in; shifts use it as the bit shifted in
//  alu_BCD    in   1  decimal mode; honoured by ADD/SUB only
//  alu_Y      out  8  registered result
//  alu_flags  out  8  registered flags {N,V,1,0,D,0,Z,C}; bit indices from params.vh
//  alu_valid  out  1  high for exactly one cycle, one clock after alu_req
// BEHAVIOUR
//  Reset (async assert, sync release): alu_Y=8'h00, alu_flags=8'h20 (UNUSED=1), alu_valid=0,
//   internal stage register cleared. Reset asserted mid-operation discards that operation: no alu_valid.
//  Latency: req sampled on edge k -> alu_Y/alu_flags/alu_valid updated on edge k+1.
//   Back-to-back requests give one result per cycle, in order.
//  Hold: cycles without alu_req leave alu_Y/alu_flags unchanged and drive alu_valid=0.
//  Ops: ADD=0 A+B+C; AND=1; OR=2; EOR=3; SL=4 {A[6:0],cin}, C=A[7]; SR=5 {cin,A[7:1]}, C=A[0];
//   SUB=6 A+~B+C (C=1 means no borrow); PASS=7 Y=A.
//  Width: sums are formed 9-bit, C=bit8.
//   V=(A[7]==B'[7])&&(Y[7]!=A[7]), where B'=B for ADD and ~B for SUB.
//  N=Y[7] and Z=(Y==0) for every op.
//   C is updated only by ADD/SUB/SL/SR; logic ops and PASS pass alu_carry through to C.
//   V is updated only by ADD/SUB; all other ops pass 0.
//  D flag bit = alu_BCD & BCD_ENABLE. B and I bits are always 0.
//  Decimal ADD (NMOS): add low nibbles; if >9, add 6 and carry into the high nibble.
//   N and V come from the value after low-nibble adjust, before high-nibble adjust.
//   Then adjust the high nibble (+6 if >9) and set C from it. Z comes from the binary sum.
//  Decimal SUB: binary subtract; subtract 6 from each nibble that borrowed. N, V, Z, C come from the binary result.
//  Invalid BCD digits (A-F) produce the deterministic NMOS arithmetic outcome; no error is signalled.
//  alu_ctrl, operands and mode bit are sampled only when alu_req=1; they are don't-care otherwise.
// STRUCTURE
//  params.vh (shared): alu_ctrl encodings ADD..PASS and flag indices CARRY, ZERO, IRQ, DECIMAL, BRK,
//   UNUSED, OVERFLOW, SIGN. The same constants are used by proc.
//  One sub-module: bcd_adjust, combinational. Inputs: binary sum, nibble carries, op.
//   Outputs: adjusted Y, C, plus the intermediate value for N/V. Instantiated only when BCD_ENABLE=1 (generate).
//  Top level: operation mux, flag logic, output/valid registers.
// TESTING
//  ADD 0x50+0x50, cin=0, BCD=0 -> Y=0xA0, N=1, V=1, Z=0, C=0, valid on the next edge only.
//  ADD BCD 0x58+0x46, cin=1 -> Y=0x05, C=1, D=1. BCD SUB 0x46-0x12, cin=1 -> Y=0x34, C=1.
//  SUB 0x00-0x01, cin=1 -> Y=0xFF, C=0, N=1, V=0. SL 0x80, cin=0 -> Y=0x00, C=1, Z=1.
//  SR 0x01, cin=1 -> Y=0x80, C=1, N=1.
//  Back-to-back reqs AND 0xF0&0x3C then EOR 0xFF^0xFF -> Y=0x30 then 0x00 (Z=1),
//   valid high two consecutive cycles. Then req low 5 cycles -> outputs held, valid=0.
//  Assert resetn low in the cycle after a req -> Y=0x00, flags=0x20, valid=0 immediately (async).
//   No valid pulse after release.
//  BCD_ENABLE=0: ADD 0x09+0x01 with BCD=1 -> Y=0x0A, D=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation encodings, status-flag bit positions and the
// request stage record used by the alu datapath.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_AND  = 3'd1,
      ALU_OR   = 3'd2,
      ALU_EOR  = 3'd3,
      ALU_SL   = 3'd4,
      ALU_SR   = 3'd5,
      ALU_SUB  = 3'd6,
      ALU_PASS = 3'd7
   } alu_op_e;

   localparam int CARRY    = 0;
   localparam int ZERO     = 1;
   localparam int IRQ      = 2;
   localparam int DECIMAL  = 3;
   localparam int BRK      = 4;
   localparam int UNUSED   = 5;
   localparam int OVERFLOW = 6;
   localparam int SIGN     = 7;

   localparam logic [7:0] FLAGS_RESET = 8'h20;

   typedef struct packed {
      logic    valid;
      alu_op_e op;
      logic [7:0] a;
      logic [7:0] b;
      logic    cin;
      logic    dec;
   } alu_stage_t;

   // Builds a P-compatible status byte; B and I are never set by the ALU.
   function automatic logic [7:0] pack_flags(input logic n, input logic v, input logic d,
                                             input logic z, input logic c);
      logic [7:0] f;
      f           = 8'h00;
      f[SIGN]     = n;
      f[OVERFLOW] = v;
      f[UNUSED]   = 1'b1;
      f[BRK]      = 1'b0;
      f[DECIMAL]  = d;
      f[IRQ]      = 1'b0;
      f[ZERO]     = z;
      f[CARRY]    = c;
      return f;
   endfunction

endpackage

// File: rtl/bcd_adjust.sv
// NMOS 6502 decimal correction applied to a binary ADD/SUB result.
// Combinational; mid_n is the sign bit seen after low-nibble adjust only.
module bcd_adjust
   import alu_pkg::*;
(
   input  logic [8:0] sum,
   input  logic       half_carry,
   input  alu_op_e    op,
   output logic [7:0] y,
   output logic       carry,
   output logic       mid_n
);

   logic       lo_fix;
   logic [3:0] lo_val;
   logic [4:0] hi_pre;

   always_comb begin
      y      = sum[7:0];
      carry  = sum[8];
      mid_n  = sum[7];
      lo_fix = 1'b0;
      lo_val = sum[3:0];
      hi_pre = sum[8:4];
      if (op == ALU_ADD) begin
         lo_fix = half_carry || (sum[3:0] > 4'd9);
         lo_val = lo_fix ? sum[3:0] + 4'd6 : sum[3:0];
         // A decimal low-digit carry that the binary add did not produce joins the high digit.
         hi_pre = sum[8:4] + {4'd0, lo_fix & ~half_carry};
         mid_n  = hi_pre[3];
         carry  = hi_pre > 5'd9;
         y      = {(carry ? hi_pre[3:0] + 4'd6 : hi_pre[3:0]), lo_val};
      end else if (op == ALU_SUB) begin
         carry = sum[8];
         y     = {(sum[8] ? sum[7:4] : sum[7:4] - 4'd6),
                  (half_carry ? sum[3:0] : sum[3:0] - 4'd6)};
      end
   end

endmodule

// File: rtl/alu.sv
// 6502 ALU: request stage register, operation/flag logic, registered result.
// alu_req is a one-cycle strobe with no back-pressure; alu_valid pulses one clock after it.
module alu
   import alu_pkg::*;
#(
   parameter bit BCD_ENABLE = 1'b1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       alu_req,
   input  logic [2:0] alu_ctrl,
   input  logic [7:0] alu_AI,
   input  logic [7:0] alu_BI,
   input  logic       alu_carry,
   input  logic       alu_BCD,
   output logic [7:0] alu_Y,
   output logic [7:0] alu_flags,
   output logic       alu_valid
);

   alu_stage_t stage;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stage <= '0;
      end else begin
         stage.valid <= alu_req;
         if (alu_req) begin
            stage.op  <= alu_op_e'(alu_ctrl);
            stage.a   <= alu_AI;
            stage.b   <= alu_BI;
            stage.cin <= alu_carry;
            stage.dec <= alu_BCD;
         end
      end
   end

   logic       dec;
   logic [7:0] b_eff;
   logic [8:0] sum;
   logic [4:0] lo_sum;
   logic [7:0] bcd_y;
   logic       bcd_c;
   logic       bcd_mid_n;

   assign dec    = stage.dec & BCD_ENABLE;
   assign b_eff  = (stage.op == ALU_SUB) ? ~stage.b : stage.b;
   assign sum    = {1'b0, stage.a} + {1'b0, b_eff} + {8'd0, stage.cin};
   assign lo_sum = {1'b0, stage.a[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, stage.cin};

   generate
      if (BCD_ENABLE) begin : g_bcd
         bcd_adjust u_bcd_adjust (
            .sum        (sum),
            .half_carry (lo_sum[4]),
            .op         (stage.op),
            .y          (bcd_y),
            .carry      (bcd_c),
            .mid_n      (bcd_mid_n)
         );
      end else begin : g_no_bcd
         assign bcd_y     = sum[7:0];
         assign bcd_c     = sum[8];
         assign bcd_mid_n = sum[7];
      end
   endgenerate

   logic [7:0] res_y;
   logic [7:0] res_flags;
   logic       f_n;
   logic       f_v;
   logic       f_z;
   logic       f_c;

   always_comb begin
      res_y = stage.a;
      f_c   = stage.cin;
      f_v   = 1'b0;
      case (stage.op)
         ALU_ADD, ALU_SUB: begin
            res_y = dec ? bcd_y : sum[7:0];
            f_c   = sum[8];
            f_v   = (stage.a[7] == b_eff[7]) && (sum[7] != stage.a[7]);
            if (dec && (stage.op == ALU_ADD)) begin
               f_c = bcd_c;
               f_v = (stage.a[7] == b_eff[7]) && (bcd_mid_n != stage.a[7]);
            end
         end
         ALU_AND:  res_y = stage.a & stage.b;
         ALU_OR:   res_y = stage.a | stage.b;
         ALU_EOR:  res_y = stage.a ^ stage.b;
         ALU_SL: begin
            res_y = {stage.a[6:0], stage.cin};
            f_c   = stage.a[7];
         end
         ALU_SR: begin
            res_y = {stage.cin, stage.a[7:1]};
            f_c   = stage.a[0];
         end
         default:  res_y = stage.a;
      endcase
      f_n = res_y[7];
      f_z = (res_y == 8'h00);
      // Decimal results report N/Z from the pre-correction value, as NMOS parts do.
      if (dec && ((stage.op == ALU_ADD) || (stage.op == ALU_SUB))) begin
         f_z = (sum[7:0] == 8'h00);
         f_n = (stage.op == ALU_ADD) ? bcd_mid_n : sum[7];
      end
      res_flags = pack_flags(f_n, f_v, dec, f_z, f_c);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         alu_Y     <= 8'h00;
         alu_flags <= FLAGS_RESET;
         alu_valid <= 1'b0;
      end else begin
         alu_valid <= stage.valid;
         if (stage.valid) begin
            alu_Y     <= res_y;
            alu_flags <= res_flags;
         end
      end
   end

endmodule
